// File: rtl/line_mem_arbiter_if.sv
// Bus bundle between the two requesters, the shared line memory and line_mem_arbiter.
// The arbiter connects through the slave modport; requesters and the memory use master.
interface line_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned LINE_W = 128
);
    logic              IF_Req;
    logic [ADDR_W-1:0] IF_Address;
    logic              IF_Ack;
    logic [LINE_W-1:0] IF_Data_Line;
    logic              DM_Req;
    logic [ADDR_W-1:0] DM_Address;
    logic              DM_Ack;
    logic [LINE_W-1:0] DM_Data_Line;
    logic [ADDR_W-1:0] Mem_Address;
    logic [LINE_W-1:0] Mem_Data_Line;
    logic              Busy;

    modport slave (
        input  IF_Req, IF_Address, DM_Req, DM_Address, Mem_Data_Line,
        output IF_Ack, IF_Data_Line, DM_Ack, DM_Data_Line, Mem_Address, Busy
    );

    modport master (
        output IF_Req, IF_Address, DM_Req, DM_Address, Mem_Data_Line,
        input  IF_Ack, IF_Data_Line, DM_Ack, DM_Data_Line, Mem_Address, Busy
    );
endinterface

// File: rtl/line_mem_arbiter.sv
// Round-robin arbiter/sequencer for the shared line-read memory: holds the line address stable
// for MEM_LATENCY edges, captures the line and returns it to the granted requester.
module line_mem_arbiter #(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned LINE_W      = 128,
    parameter int unsigned MEM_LATENCY = 5,
    parameter int unsigned CNT_W       = 4
) (
    input logic               Clock,
    input logic               Reset_n,
    line_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic              r_grant_dm;
    logic              r_last_dm;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_if_line;
    logic [LINE_W-1:0] r_dm_line;
    logic              w_req_any;
    logic              w_pick_dm;
    logic              w_cnt_done;

    assign w_req_any  = bus.IF_Req | bus.DM_Req;
    // DM wins only when alone, or on a tie when IF was served last.
    assign w_pick_dm  = bus.DM_Req & (~bus.IF_Req | ~r_last_dm);
    assign w_cnt_done = (r_cnt == CNT_W'(MEM_LATENCY));

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_req_any) w_state_d = StWait;
            StWait:  if (w_cnt_done) w_state_d = StResp;
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.Busy   = (r_state != StIdle);
        bus.IF_Ack = (r_state == StResp) & ~r_grant_dm;
        bus.DM_Ack = (r_state == StResp) & r_grant_dm;
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_grant_dm <= 1'b0;
            r_last_dm  <= 1'b1;
            r_cnt      <= '0;
            r_mem_addr <= '0;
            r_if_line  <= '0;
            r_dm_line  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_req_any) begin
                        r_grant_dm <= w_pick_dm;
                        r_cnt      <= '0;
                        r_mem_addr <= w_pick_dm ? {bus.DM_Address[ADDR_W-1:4], 4'b0000}
                                                : {bus.IF_Address[ADDR_W-1:4], 4'b0000};
                    end
                end
                StWait: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_cnt_done) begin
                        r_last_dm <= r_grant_dm;
                        if (r_grant_dm) begin
                            r_dm_line <= bus.Mem_Data_Line;
                        end else begin
                            r_if_line <= bus.Mem_Data_Line;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Mem_Address  = r_mem_addr;
    assign bus.IF_Data_Line = r_if_line;
    assign bus.DM_Data_Line = r_dm_line;
endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed bench for line_mem_arbiter: one DUT with MEM_LATENCY=5 and one with MEM_LATENCY=1,
// each fed by a memory model that only returns valid data once the address has been held.
module tb_line_mem_arbiter;
    localparam logic [127:0] LineAt20 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] LineAt10 = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;
    localparam logic [127:0] LineAt40 = 128'h2F2E2D2C2B2A29282726252423222120;
    localparam logic [127:0] LineAt80 = 128'h6F6E6D6C6B6A69686766656463626160;

    logic Clock = 1'b0;
    logic Reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    line_mem_arbiter_if #(.ADDR_W(64), .LINE_W(128)) b0 ();
    line_mem_arbiter_if #(.ADDR_W(64), .LINE_W(128)) b1 ();

    line_mem_arbiter #(.ADDR_W(64), .LINE_W(128), .MEM_LATENCY(5), .CNT_W(4)) u_dut0 (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (b0)
    );

    line_mem_arbiter #(.ADDR_W(64), .LINE_W(128), .MEM_LATENCY(1), .CNT_W(4)) u_dut1 (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (b1)
    );

    always #5 Clock = ~Clock;

    // Byte at address A holds (A - 0x20) & 0xFF.
    function automatic logic [127:0] mem_line(input logic [63:0] a);
        logic [127:0] l;
        logic [63:0]  v;
        for (int k = 0; k < 16; k++) begin
            v = a + 64'(k) - 64'h20;
            l[8*k +: 8] = v[7:0];
        end
        return l;
    endfunction

    // Memory models: data valid only after the address was seen stable for LATENCY edges.
    logic [63:0] m0_addr = '0;
    logic [7:0]  m0_cnt  = '0;
    logic [63:0] m1_addr = '0;
    logic [7:0]  m1_cnt  = '0;

    always @(posedge Clock) begin
        if (b0.Mem_Address == m0_addr) begin
            if (m0_cnt != 8'hFF) m0_cnt <= m0_cnt + 8'd1;
        end else begin
            m0_addr <= b0.Mem_Address;
            m0_cnt  <= 8'd1;
        end
        if (b1.Mem_Address == m1_addr) begin
            if (m1_cnt != 8'hFF) m1_cnt <= m1_cnt + 8'd1;
        end else begin
            m1_addr <= b1.Mem_Address;
            m1_cnt  <= 8'd1;
        end
    end

    assign b0.Mem_Data_Line = (b0.Mem_Address == m0_addr && m0_cnt >= 8'd5) ?
                              mem_line(m0_addr) : {8{16'hDEAD}};
    assign b1.Mem_Data_Line = (b1.Mem_Address == m1_addr && m1_cnt >= 8'd1) ?
                              mem_line(m1_addr) : {8{16'hDEAD}};

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until the selected Ack rises (-1 if it never does within 20 edges).
    task automatic wait_ack(input bit inst1, input bit dm, output int ticks, output bit other);
        logic a;
        logic o;
        ticks = -1;
        other = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            a = inst1 ? (dm ? b1.DM_Ack : b1.IF_Ack) : (dm ? b0.DM_Ack : b0.IF_Ack);
            o = inst1 ? (dm ? b1.IF_Ack : b1.DM_Ack) : (dm ? b0.IF_Ack : b0.DM_Ack);
            if (o) other = 1'b1;
            if (a) begin
                ticks = i;
                return;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  t;
        bit  oth;
        int  n_ack;
        int  ack_tick [8];
        bit  ack_dm   [8];
        bit  coinc;

        b0.IF_Req = 0; b0.DM_Req = 0; b0.IF_Address = '0; b0.DM_Address = '0;
        b1.IF_Req = 0; b1.DM_Req = 0; b1.IF_Address = '0; b1.DM_Address = '0;

        // Reset held 3 edges with both requests high.
        Reset_n = 0;
        b0.IF_Req = 1; b0.DM_Req = 1;
        b0.IF_Address = 64'h24; b0.DM_Address = 64'h40;
        repeat (3) tick();
        check("rst_if_ack",  b0.IF_Ack, 0);
        check("rst_dm_ack",  b0.DM_Ack, 0);
        check("rst_busy",    b0.Busy, 0);
        check("rst_mem_addr", b0.Mem_Address, 0);
        check("rst_if_line", b0.IF_Data_Line, 0);
        check("rst_dm_line", b0.DM_Data_Line, 0);

        // Release: IF wins the first tie; then single IF transaction at 0x24.
        Reset_n = 1;
        tick();
        check("grant_busy", b0.Busy, 1);
        check("grant_mem_addr_if", b0.Mem_Address, 64'h20);
        b0.DM_Req = 0;
        wait_ack(0, 0, t, oth);
        check("if_latency_edges", 128'(t), 6);
        check("if_line", b0.IF_Data_Line, LineAt20);
        check("if_no_dm_ack", 128'(oth), 0);
        check("if_mem_addr_held", b0.Mem_Address, 64'h20);
        b0.IF_Req = 0;
        tick();
        check("if_ack_pulse", b0.IF_Ack, 0);
        check("if_idle_busy", b0.Busy, 0);

        // Both requesters held high: IF, DM, IF, DM, 8 cycles apart.
        Reset_n = 0;
        tick();
        Reset_n = 1;
        b0.IF_Address = 64'h10; b0.DM_Address = 64'h40;
        b0.IF_Req = 1; b0.DM_Req = 1;
        n_ack = 0;
        coinc = 0;
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (b0.IF_Ack && b0.DM_Ack) coinc = 1;
            if (b0.IF_Ack || b0.DM_Ack) begin
                if (n_ack < 8) begin
                    ack_tick[n_ack] = i;
                    ack_dm[n_ack]   = b0.DM_Ack;
                end
                if (b0.DM_Ack) check("rr_dm_line", b0.DM_Data_Line, LineAt40);
                else           check("rr_if_line", b0.IF_Data_Line, LineAt10);
                n_ack++;
            end
        end
        check("rr_ack_count", 128'(n_ack), 4);
        check("rr_coincident", 128'(coinc), 0);
        for (int k = 0; k < 4; k++) begin
            check("rr_ack_tick", 128'(ack_tick[k]), 128'(7 + 8 * k));
            check("rr_ack_who", 128'(ack_dm[k]), 128'(k % 2));
        end
        b0.IF_Req = 0; b0.DM_Req = 0;
        tick();
        check("rr_idle_busy", b0.Busy, 0);

        // DM at 0x40, address changed at +2 and Req dropped at +3.
        Reset_n = 0;
        tick();
        Reset_n = 1;
        b0.DM_Address = 64'h40; b0.DM_Req = 1;
        tick();
        check("chg_mem_addr_grant", b0.Mem_Address, 64'h40);
        tick();
        b0.DM_Address = 64'h80;
        tick();
        b0.DM_Req = 0;
        wait_ack(0, 1, t, oth);
        check("chg_ack_edges", 128'(t), 4);
        check("chg_mem_addr_held", b0.Mem_Address, 64'h40);
        check("chg_dm_line", b0.DM_Data_Line, LineAt40);
        check("chg_if_line_untouched", b0.IF_Data_Line, 0);
        check("chg_no_if_ack", 128'(oth), 0);
        tick();
        check("chg_ack_pulse", b0.DM_Ack, 0);

        // Reset at counter=3 drops the transaction; a new DM request takes the full latency.
        b0.DM_Address = 64'h80; b0.DM_Req = 1;
        repeat (4) tick();
        check("midrst_busy_before", b0.Busy, 1);
        Reset_n = 0;
        tick();
        check("midrst_busy", b0.Busy, 0);
        check("midrst_dm_ack", b0.DM_Ack, 0);
        check("midrst_mem_addr", b0.Mem_Address, 0);
        Reset_n = 1;
        wait_ack(0, 1, t, oth);
        check("midrst_new_latency", 128'(t), 7);
        check("midrst_dm_line", b0.DM_Data_Line, LineAt80);
        check("midrst_mem_addr_new", b0.Mem_Address, 64'h80);
        b0.DM_Req = 0;
        tick();

        // MEM_LATENCY=1 instance.
        b1.IF_Address = 64'h24; b1.IF_Req = 1;
        wait_ack(1, 0, t, oth);
        check("lat1_if_edges", 128'(t), 3);
        check("lat1_if_line", b1.IF_Data_Line, LineAt20);
        b1.IF_Req = 0;
        tick();
        check("lat1_idle_busy", b1.Busy, 0);
        b1.DM_Address = 64'h4C; b1.DM_Req = 1;
        wait_ack(1, 1, t, oth);
        check("lat1_dm_edges", 128'(t), 3);
        check("lat1_dm_line", b1.DM_Data_Line, LineAt40);
        check("lat1_if_line_kept", b1.IF_Data_Line, LineAt20);
        b1.DM_Req = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
